dbus_sram_responder: RTL

DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

---
 rtl/dbus_sram_responder_pkg.sv | 28 ++
 rtl/dbus_sram_responder_if.sv | 11 +
 rtl/dbus_sram_responder_sram.sv | 26 ++
 rtl/dbus_sram_responder.sv | 98 +++++++++
 4 files changed

// File: rtl/dbus_sram_responder_pkg.sv
// Shared mycpu types for the data-bus SRAM responder: FSM states, default parameters, bus structs.
// Pure declarations; no latency or backpressure of its own.
package dbus_sram_responder_pkg;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_DEPTH_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Core-side data bus: request toward the responder, response back to the core.
// Handshake is addr_ok (accept) then data_ok (completion); the responder takes one request at a time.
interface dbus_sram_responder_if;
    import dbus_sram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder_sram.sv
// Word-wide storage with per-byte write enables; asynchronous read, write on the rising edge.
// Always ready: no backpressure, contents are never reset.
module bytewe_sram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata
);
    logic [31:0] r_mem [DEPTH_WORDS];

    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency SRAM slave on the core data bus: addr_ok on acceptance, data_ok exactly LATENCY cycles later.
// Single outstanding request; addr_ok is withheld in WAIT/RESP, which is the only backpressure.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int LATENCY     = DEF_LATENCY,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                 clk,
    input  logic                 resetn,
    dbus_sram_responder_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    rsp_state_e    r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_strobe;
    logic [31:0]   r_wdata;
    logic          w_accept;
    logic          w_we;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // size is the core's concern; byte offset and address bits above the array alias away
    assign w_unused = ^{bus.dreq.size, bus.dreq.addr[31:2+AW], bus.dreq.addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_strobe <= 4'd0;
            r_wdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx    <= bus.dreq.addr[2 +: AW];
                r_strobe <= bus.dreq.strobe;
                r_wdata  <= bus.dreq.data;
            end
        end
    end

    // WAIT spans LATENCY-1 cycles: leave it on the cycle the counter would reach zero
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.dreq.valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_state_nxt = RESP;
            end
            RESP: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.dresp         = '0;
        bus.dresp.addr_ok = resetn && (r_state == IDLE) && bus.dreq.valid;
        if (r_state == RESP) begin
            bus.dresp.data_ok = 1'b1;
            bus.dresp.data    = w_rdata;
        end
    end

    // write lands on the RESP edge, so the response carries the pre-write word
    assign w_we = (r_state == RESP) && (r_strobe != 4'd0);

    bytewe_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .i_raddr (r_idx),
        .o_rdata (w_rdata),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_be    (r_strobe),
        .i_wdata (r_wdata)
    );
endmodule
